muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in WIDTH, sitting beside the single-cycle ALU in the execute stage.
- Accepts one operation via a valid/ready handshake and computes it with a radix-2 shift-add or restoring-divide loop.
- Presents the WIDTH-bit result with a valid/ready handshake; the core stalls while the unit is busy.
- Handles the RISC-V divide-by-zero and signed-overflow cases with a short-circuit path.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct3 operation codes, FSM state encoding and small op-decode helpers.
package muldiv_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
    localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
    localparam logic [OP_W-1:0] OP_REM    = 3'd6;
    localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Divide-class ops (DIV/DIVU/REM/REMU) all have funct3[2] set.
    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    // Remainder ops (REM/REMU) are the divide ops with funct3[1] set.
    function automatic logic is_rem(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration shared by multiply and divide.
//   acc      : {hi, lo} working register (product or {remainder, dividend/quotient})
//   opnd     : multiplicand (multiply) or divisor (divide)
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_next : updated working register (divide leaves bit 0 clear)
//   q_bit    : quotient bit produced by a divide step (0 when multiplying)
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_ext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign borrow  = rem_ext < {1'b0, opnd};
    // Only used when no borrow, where the true difference fits in WIDTH bits.
    assign diff    = rem_ext[WIDTH-1:0] - opnd;

    always_comb begin
        acc_next = acc;
        q_bit    = 1'b0;
        if (div_mode) begin
            q_bit    = ~borrow;
            acc_next = {(borrow ? rem_ext[WIDTH-1:0] : diff), acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : request handshake; op/a/b captured on accept
//   op, a, b              : funct3 operation and rs1/rs2 operands
//   flush                 : abort any in-flight operation on the next edge
//   out_valid/out_ready   : result handshake; result held under backpressure
//   result                : computed value (qualify with out_valid)
//   busy                  : unit is not idle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned    CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic                   neg_q, neg_d;
    logic [WIDTH-1:0]       result_d;
    logic                   out_valid_d, in_ready_d, busy_d;

    logic                   a_neg, b_neg, neg_c;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic                   special;
    logic [WIDTH-1:0]       special_val;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       div_sel, fix_val;
    logic [2*WIDTH-1:0]     step_acc;
    logic                   step_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .opnd     (opnd_q),
        .div_mode (is_div(op_q)),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Operand preparation: magnitudes, result sign and short-circuit cases.
    always_comb begin
        a_neg = a[WIDTH-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
        b_neg = b[WIDTH-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
        neg_c = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        special     = 1'b0;
        special_val = '0;
        if (is_div(op) && (b == '0)) begin
            special     = 1'b1;
            special_val = is_rem(op) ? a : '1;
        end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1)) begin
            special     = 1'b1;
            special_val = (op == OP_DIV) ? a : '0;
        end
    end

    // Sign fix-up and result selection; the product is negated at full width
    // so the high half carries the borrow from the low half.
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        div_sel = is_rem(op_q) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        if (is_div(op_q)) begin
            fix_val = neg_q ? -div_sel : div_sel;
        end else if (op_q == OP_MUL) begin
            fix_val = prod[WIDTH-1:0];
        end else begin
            fix_val = prod[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    neg_d  = neg_c;
                    acc_d  = {{WIDTH{1'b0}}, mag_a};
                    opnd_d = mag_b;
                    cnt_d  = '0;
                    if (special) begin
                        result_d = special_val;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end else begin
                    acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result;
        end
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            result    <= result_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) with an expected-result queue.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;
    localparam int NORM_LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    endtask

    // Reference model written directly from RV32M semantics.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx64, sy64, uy64s;
        logic [2*W-1:0]        p;
        logic signed [W-1:0]   sx, sy;
        logic                  ovf;
        sx64  = {{W{x[W-1]}}, x};
        sy64  = {{W{y[W-1]}}, y};
        uy64s = {{W{1'b0}}, y};
        sx    = x;
        sy    = y;
        ovf   = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; return p[W-1:0]; end
            OP_MULH:   begin p = sx64 * sy64;  return p[2*W-1:W]; end
            OP_MULHSU: begin p = sx64 * uy64s; return p[2*W-1:W]; end
            OP_MULHU:  begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; return p[2*W-1:W]; end
            OP_DIV:    return (y == '0) ? '1 : (ovf ? x : W'(sx / sy));
            OP_DIVU:   return (y == '0) ? '1 : x / y;
            OP_REM:    return (y == '0) ? x : (ovf ? '0 : W'(sx % sy));
            default:   return (y == '0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (o[2] && (y == '0)) return 0;
        if (((o == OP_DIV) || (o == OP_REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 0;
        return NORM_LAT;
    endfunction

    // Present one request; it is accepted on the following rising edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_issue", W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (latency counted in edges after the accept edge),
    // optionally hold backpressure, then compare against the queue head.
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int lat;
        logic rdy_seen, unstable;
        logic [W-1:0] first;
        logic [W-1:0] exp;
        lat = 0; rdy_seen = 1'b0; unstable = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        check({tag, "_in_ready_low"}, W'(rdy_seen), W'(0));
        first = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== first) unstable = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, W'(unstable), W'(0));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, W'(1), W'(0));
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, result, exp);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check({tag, "_idle_after"}, W'({out_valid, in_ready}), W'(2'b01));
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp, input int lat, input string tag);
        exp_q.push_back(exp);
        issue(o, x, y);
        collect(tag, lat, 0);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] rx, ry;
        logic         seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", W'({in_ready, out_valid, busy}), W'(3'b100));
        check("reset_result", result, '0);
        @(negedge clk); rst_n = 1'b1;

        run(OP_MUL,    32'd7,          32'd6,          32'd42,         NORM_LAT, "mul_7x6");
        run(OP_MULH,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  NORM_LAT, "mulh");
        run(OP_MULHU,  32'hFFFF_FFFE,  32'd3,          32'h0000_0002,  NORM_LAT, "mulhu");
        run(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  NORM_LAT, "mulhsu");
        run(OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM_LAT, "div_m7_2");
        run(OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM_LAT, "rem_m7_2");
        run(OP_DIVU,   32'd100,        32'd7,          32'd14,         NORM_LAT, "divu_100_7");
        run(OP_REMU,   32'd100,        32'd7,          32'd2,          NORM_LAT, "remu_100_7");
        // Short-circuit cases: result visible in the cycle right after accept.
        run(OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  0, "divu_by0");
        run(OP_REMU,   32'd5,          32'd0,          32'd5,          0, "remu_by0");
        run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, "div_ovf");
        run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, "rem_ovf");

        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom;
            run(ro, rx, ry, model(ro, rx, ry), model_lat(ro, rx, ry), $sformatf("rand%0d_op%0d", i, ro));
        end

        // Backpressure for 10 cycles, then a back-to-back request.
        exp_q.push_back(32'd391);
        issue(OP_MUL, 32'd17, 32'd23);
        collect("backpressure", NORM_LAT, 10);
        run(OP_REMU, 32'd1000, 32'd33, 32'd10, NORM_LAT, "back_to_back");

        // Flush at CALC cycle 5: no result may appear.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_idle", W'({in_ready, out_valid, busy}), W'(3'b100));
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        check("flush_blocks_accept", W'({in_ready, busy}), W'(2'b10));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", W'(seen), W'(0));
        run(OP_MUL, 32'd12345, 32'd1000, 32'd12345000, NORM_LAT, "after_flush");

        // Reset mid-CALC returns outputs to reset values immediately.
        issue(OP_MUL, 32'h1234, 32'h5678);
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midreset_outputs", W'({in_ready, out_valid, busy}), W'(3'b100));
        check("midreset_result", result, '0);
        @(negedge clk); rst_n = 1'b1;
        run(OP_MULHU, 32'h8000_0001, 32'h0000_0010, model(OP_MULHU, 32'h8000_0001, 32'h0000_0010),
            NORM_LAT, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
